instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/msp430_pkg.sv | 39 +++
 rtl/ext_word_count.sv | 36 +++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msp430_pkg.sv
// Shared MSP430 front-end definitions: fetch FSM encoding, reset defaults and
// opcode format masks used by both instruction fetch and decode.
package msp430_pkg;

  typedef enum logic [2:0] {
    ST_VEC   = 3'd0,
    ST_OP    = 3'd1,
    ST_SRC   = 3'd2,
    ST_DST   = 3'd3,
    ST_ISSUE = 3'd4
  } fetch_state_e;

  localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFE;
  localparam logic [15:0] NOP_WORD_DEF     = 16'h4303;

  localparam logic [15:0] FMT1_MASK  = 16'hF000;
  localparam logic [15:0] FMT1_MIN   = 16'h4000;
  localparam logic [15:0] FMT2_MASK  = 16'hFC00;
  localparam logic [15:0] FMT2_MATCH = 16'h1000;
  localparam logic [15:0] FMT3_MASK  = 16'hE000;
  localparam logic [15:0] FMT3_MATCH = 16'h2000;

  function automatic logic is_fmt1(input logic [15:0] w);
    return (w & FMT1_MASK) >= FMT1_MIN;
  endfunction

  function automatic logic is_fmt2(input logic [15:0] w);
    return (w & FMT2_MASK) == FMT2_MATCH;
  endfunction

  function automatic logic is_fmt3(input logic [15:0] w);
    return (w & FMT3_MASK) == FMT3_MATCH;
  endfunction

  function automatic logic [15:0] word_align(input logic [15:0] a);
    return a & 16'hFFFE;
  endfunction

endpackage

// File: rtl/ext_word_count.sv
// Combinational detection of the extension words an opcode word pulls in:
// one for an indexed/absolute/immediate source, one for an indexed destination.
module ext_word_count
  import msp430_pkg::*;
(
  input  logic [15:0] word_i,
  output logic        need_src_o,
  output logic        need_dst_o
);

  logic       fmt1_s;
  logic       fmt2_s;
  logic [3:0] src_reg_s;
  logic       src_mode_s;

  // Format III jumps and unlisted encodings fall out as neither format I nor II.
  always_comb begin
    fmt1_s     = is_fmt1(word_i);
    fmt2_s     = is_fmt2(word_i);
    src_reg_s  = 4'd0;
    src_mode_s = 1'b0;
    if (fmt1_s) begin
      src_reg_s = word_i[11:8];
    end else begin
      src_reg_s = word_i[3:0];
    end
    case (word_i[5:4])
      2'b01:   src_mode_s = (src_reg_s != 4'd3);
      2'b11:   src_mode_s = (src_reg_s == 4'd0);
      default: src_mode_s = 1'b0;
    endcase
    need_src_o = (fmt1_s | fmt2_s) & src_mode_s;
    need_dst_o = fmt1_s & word_i[7];
  end

endmodule

// File: rtl/instr_fetch.sv
// MSP430 instruction fetch: reads the reset vector, then fetches opcode plus
// extension words and holds the complete instruction until decode accepts it.
module instr_fetch
  import msp430_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [15:0] NOP_WORD     = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MDB_out,
  output logic [15:0] MAB,
  output logic        MRD,
  input  logic        pc_load,
  input  logic [15:0] pc_new,
  input  logic        dec_ready,
  output logic        ir_valid,
  output logic [15:0] IR,
  output logic [15:0] EXT_SRC,
  output logic [15:0] EXT_DST,
  output logic [15:0] PC
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  ir_q;
  logic [15:0]  ext_src_q;
  logic [15:0]  ext_dst_q;
  logic [15:0]  pc_inc_d;
  logic [15:0]  dec_word_s;
  logic         need_src_s;
  logic         need_dst_s;

  // In OP the word is still on the bus; later states look at the captured IR.
  always_comb begin
    pc_inc_d = pc_q + 16'd2;
    if (state_q == ST_OP) begin
      dec_word_s = MDB_out;
    end else begin
      dec_word_s = ir_q;
    end
  end

  ext_word_count u_ext_word_count (
    .word_i     (dec_word_s),
    .need_src_o (need_src_s),
    .need_dst_o (need_dst_s)
  );

  // Bus strobes and handshake flag decode straight from the state register.
  always_comb begin
    if (state_q == ST_VEC) begin
      MAB = word_align(RESET_VECTOR);
    end else begin
      MAB = pc_q;
    end
    MRD      = (state_q != ST_ISSUE);
    ir_valid = (state_q == ST_ISSUE);
  end

  // Fetch sequencer; a redirect outranks both the PC increment and the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_VEC;
      pc_q      <= 16'h0000;
      ir_q      <= NOP_WORD;
      ext_src_q <= 16'h0000;
      ext_dst_q <= 16'h0000;
    end else if ((state_q != ST_VEC) && pc_load) begin
      state_q   <= ST_OP;
      pc_q      <= word_align(pc_new);
      ir_q      <= NOP_WORD;
      ext_src_q <= 16'h0000;
      ext_dst_q <= 16'h0000;
    end else begin
      case (state_q)
        ST_VEC: begin
          pc_q    <= word_align(MDB_out);
          state_q <= ST_OP;
        end
        ST_OP: begin
          ir_q      <= MDB_out;
          ext_src_q <= 16'h0000;
          ext_dst_q <= 16'h0000;
          pc_q      <= pc_inc_d;
          if (need_src_s) begin
            state_q <= ST_SRC;
          end else if (need_dst_s) begin
            state_q <= ST_DST;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_SRC: begin
          ext_src_q <= MDB_out;
          pc_q      <= pc_inc_d;
          if (need_dst_s) begin
            state_q <= ST_DST;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_DST: begin
          ext_dst_q <= MDB_out;
          pc_q      <= pc_inc_d;
          state_q   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (dec_ready) begin
            state_q <= ST_OP;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        default: begin
          state_q <= ST_VEC;
        end
      endcase
    end
  end

  assign IR      = ir_q;
  assign EXT_SRC = ext_src_q;
  assign EXT_DST = ext_dst_q;
  assign PC      = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed sequences, a vector table and
// a randomized run against a transaction-level fetch model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_load = 1'b0;
  logic        dec_ready = 1'b0;
  logic [15:0] pc_new = 16'h0000;
  logic [15:0] MDB_out, MAB, IR, EXT_SRC, EXT_DST, PC;
  logic        MRD, ir_valid;
  logic [15:0] mem [0:32767];
  int          checks = 0;
  int          errors = 0;

  assign MDB_out = mem[MAB[15:1]];

  instr_fetch #(.RESET_VECTOR(16'hFFFE), .NOP_WORD(16'h4303)) dut (
    .clk(clk), .rst(rst), .MDB_out(MDB_out), .MAB(MAB), .MRD(MRD),
    .pc_load(pc_load), .pc_new(pc_new), .dec_ready(dec_ready),
    .ir_valid(ir_valid), .IR(IR), .EXT_SRC(EXT_SRC), .EXT_DST(EXT_DST), .PC(PC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem[a[15:1]] = d;
  endtask

  // Extension word counts straight from the instruction-set rules.
  function automatic int src_words(input logic [15:0] w);
    int r;
    int as_mode;
    if (w[15:12] >= 4'd4) r = int'(w[11:8]);
    else if (w[15:10] == 6'b000100) r = int'(w[3:0]);
    else return 0;
    as_mode = int'(w[5:4]);
    if (as_mode == 1 && r != 3) return 1;
    if (as_mode == 3 && r == 0) return 1;
    return 0;
  endfunction

  function automatic int dst_words(input logic [15:0] w);
    return (w[15:12] >= 4'd4 && w[7]) ? 1 : 0;
  endfunction

  task automatic redirect(input logic [15:0] tgt);
    pc_load = 1'b1;
    pc_new  = tgt;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic wait_issue(output int cyc);
    cyc = 0;
    while (!ir_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [15:0] w0, w1, w2, src, dst;
    int          lat;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int          cyc;
    logic [15:0] base;
    logic [15:0] mpc;
    logic [15:0] a;
    int          k, n, ns;
    bit          mv, iv_exp;

    for (int i = 0; i < 32768; i++) mem[i] = 16'h4303;
    wr(16'hFFFE, 16'hC000);
    wr(16'hC000, 16'h4031); wr(16'hC002, 16'h0400);
    wr(16'hC004, 16'h4592); wr(16'hC006, 16'h0002); wr(16'hC008, 16'h0004);
    wr(16'hC00A, 16'h4303);

    // Reset state and vector fetch
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_MAB", MAB, 16'hFFFE);
    chk("rst_MRD", {15'd0, MRD}, 16'd1);
    chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_IR", IR, 16'h4303);
    chk("rst_PC", PC, 16'h0000);
    chk("rst_EXT_SRC", EXT_SRC, 16'h0000);
    chk("rst_EXT_DST", EXT_DST, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("op1_MAB", MAB, 16'hC000);
    chk("op1_PC", PC, 16'hC000);
    chk("op1_ir_valid", {15'd0, ir_valid}, 16'd0);
    @(negedge clk);
    chk("src1_PC", PC, 16'hC002);
    chk("src1_MAB", MAB, 16'hC002);
    chk("src1_IR", IR, 16'h4031);
    @(negedge clk);
    chk("iss1_ir_valid", {15'd0, ir_valid}, 16'd1);
    chk("iss1_EXT_SRC", EXT_SRC, 16'h0400);
    chk("iss1_EXT_DST", EXT_DST, 16'h0000);
    chk("iss1_MRD", {15'd0, MRD}, 16'd0);
    chk("iss1_PC", PC, 16'hC004);

    // Decoder stall holds the instruction
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_ir_valid", {15'd0, ir_valid}, 16'd1);
      chk("stall_MRD", {15'd0, MRD}, 16'd0);
      chk("stall_IR", IR, 16'h4031);
      chk("stall_EXT_SRC", EXT_SRC, 16'h0400);
      chk("stall_PC", PC, 16'hC004);
    end
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    chk("accept_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("accept_MAB", MAB, 16'hC004);
    wait_issue(cyc);
    chk("mov_idx_lat", 16'(cyc), 16'd3);
    chk("mov_idx_IR", IR, 16'h4592);
    chk("mov_idx_EXT_SRC", EXT_SRC, 16'h0002);
    chk("mov_idx_EXT_DST", EXT_DST, 16'h0004);
    chk("mov_idx_PC", PC, 16'hC00A);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    chk("nop_MAB", MAB, 16'hC00A);
    wait_issue(cyc);
    chk("nop_lat", 16'(cyc), 16'd1);
    chk("nop_EXT_SRC", EXT_SRC, 16'h0000);
    chk("nop_PC", PC, 16'hC00C);

    // Vector table: opcode + extension words -> captured fields and latency
    tbl[0]  = '{16'h4031, 16'h0400, 16'h0000, 16'h0400, 16'h0000, 2};
    tbl[1]  = '{16'h4592, 16'h0002, 16'h0004, 16'h0002, 16'h0004, 3};
    tbl[2]  = '{16'h4303, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1};
    tbl[3]  = '{16'h40B2, 16'h1234, 16'h0200, 16'h1234, 16'h0200, 3};
    tbl[4]  = '{16'h1290, 16'h0010, 16'h3333, 16'h0010, 16'h0000, 2};
    tbl[5]  = '{16'h2400, 16'h4444, 16'h5555, 16'h0000, 16'h0000, 1};
    tbl[6]  = '{16'h4382, 16'h0300, 16'h6666, 16'h0000, 16'h0300, 2};
    tbl[7]  = '{16'h4213, 16'h0120, 16'h7777, 16'h0120, 16'h0000, 2};
    tbl[8]  = '{16'h4331, 16'h8888, 16'h9999, 16'h0000, 16'h0000, 1};
    tbl[9]  = '{16'h1034, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 1};
    tbl[10] = '{16'h1030, 16'h0ABC, 16'hCCCC, 16'h0ABC, 16'h0000, 2};
    for (int i = 0; i < 11; i++) begin
      base = 16'h2000 + 16'(i * 16);
      wr(base, tbl[i].w0);
      wr(base + 16'd2, tbl[i].w1);
      wr(base + 16'd4, tbl[i].w2);
      redirect(base | 16'h0001);
      chk("tbl_MAB", MAB, base);
      wait_issue(cyc);
      chk("tbl_lat", 16'(cyc), 16'(tbl[i].lat));
      chk("tbl_IR", IR, tbl[i].w0);
      chk("tbl_EXT_SRC", EXT_SRC, tbl[i].src);
      chk("tbl_EXT_DST", EXT_DST, tbl[i].dst);
      chk("tbl_PC", PC, base + 16'(2 * tbl[i].lat));
      dec_ready = 1'b1;
      @(negedge clk);
      dec_ready = 1'b0;
      chk("tbl_after_ir_valid", {15'd0, ir_valid}, 16'd0);
    end

    // Redirect while fetching the source extension word
    wr(16'h3000, 16'h4031); wr(16'h3002, 16'h1111); wr(16'hF000, 16'h4303);
    redirect(16'h3000);
    @(negedge clk);
    chk("src_redir_MAB_before", MAB, 16'h3002);
    redirect(16'hF001);
    chk("src_redir_PC", PC, 16'hF000);
    chk("src_redir_MAB", MAB, 16'hF000);
    chk("src_redir_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("src_redir_IR", IR, 16'h4303);
    wait_issue(cyc);
    chk("src_redir_lat", 16'(cyc), 16'd1);
    chk("src_redir_PC2", PC, 16'hF002);

    // PC wraps from the top word to zero
    redirect(16'hFFFE);
    chk("wrap_MAB", MAB, 16'hFFFE);
    wait_issue(cyc);
    chk("wrap_PC", PC, 16'h0000);
    chk("wrap_IR", IR, 16'hC000);

    // Reset mid-fetch aborts; redirect during the vector read is ignored
    redirect(16'h2010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("midrst_MAB", MAB, 16'hFFFE);
    chk("midrst_PC", PC, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    pc_load = 1'b1;
    pc_new = 16'h1234;
    @(negedge clk);
    pc_load = 1'b0;
    chk("vec_ignore_MAB", MAB, 16'hC000);
    chk("vec_ignore_ir_valid", {15'd0, ir_valid}, 16'd0);

    // Randomized run against the transaction-level model
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mv = 1'b0; mpc = 16'h0000; k = 0; n = 0; ns = 0;
    for (int c = 0; c < 3000; c++) begin
      if (mv) begin
        iv_exp = (k == 1 + n);
        a = mpc + 16'(2 * k);
        chk("rnd_ir_valid", {15'd0, ir_valid}, {15'd0, iv_exp});
        chk("rnd_MRD", {15'd0, MRD}, {15'd0, !iv_exp});
        chk("rnd_PC", PC, a);
        if (!iv_exp) begin
          chk("rnd_MAB", MAB, a);
        end else begin
          chk("rnd_IR", IR, rd(mpc));
          chk("rnd_EXT_SRC", EXT_SRC, (ns != 0) ? rd(mpc + 16'd2) : 16'h0000);
          chk("rnd_EXT_DST", EXT_DST, (n > ns) ? rd(mpc + 16'(2 + 2 * ns)) : 16'h0000);
        end
      end
      pc_load   = (c == 0) || ($urandom_range(0, 11) == 0);
      pc_new    = 16'($urandom);
      dec_ready = 1'($urandom_range(0, 1));
      iv_exp    = mv && (k == 1 + n);
      if (pc_load) begin
        mpc = pc_new & 16'hFFFE;
        k = 0;
      end else if (iv_exp && dec_ready) begin
        mpc = mpc + 16'(2 * (1 + n));
        k = 0;
      end else if (k < 1 + n) begin
        k++;
      end
      ns = src_words(rd(mpc));
      n  = ns + dst_words(rd(mpc));
      mv = 1'b1;
      @(negedge clk);
    end
    pc_load = 1'b0;
    dec_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
